// File: rtl/xor_seq_pkg.sv
// Shared types for the bit-serial XOR arbiter: FSM state encoding and default operand width.
package xor_seq_pkg;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/xor_seq_arbiter_if.sv
// Requester/consumer bundle for xor_seq_arbiter; the slave modport is the arbiter's view.
interface xor_seq_arbiter_if import xor_seq_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/xor_seq_arbiter_xor.sv
// Single 1-bit XOR gate; the only XOR on the arbiter's serial datapath.
module xor_seq_arbiter_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/xor_seq_arbiter.sv
// Two-requester round-robin arbiter computing a XOR b one bit per cycle; result valid WIDTH cycles after accept.
// Result is held in DONE until res_ready; no request is accepted outside IDLE.
module xor_seq_arbiter import xor_seq_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  xor_seq_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic             ptr;
  logic             grant;
  logic             id_q;
  logic             res_vld_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res_q;
  logic             bit_x;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ptr;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
  assign bus.res_valid  = res_vld_q;
  assign bus.res_data   = res_q;
  assign bus.res_id     = id_q;
  assign bus.busy       = busy_q;
  assign cnt_nxt        = cnt + CNT_W'(1);

  xor_seq_arbiter_xor u_xor (
    .a (sh_a[0]),
    .b (sh_b[0]),
    .y (bit_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      res_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready || bus.req1_ready) begin
            sh_a   <= grant ? bus.req1_a : bus.req0_a;
            sh_b   <= grant ? bus.req1_b : bus.req0_b;
            id_q   <= grant;
            cnt    <= '0;
            res_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // LSB is computed first and enters at the MSB, so after WIDTH shifts bit order is natural.
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res_q <= (res_q >> 1) | (WIDTH'(bit_x) << (WIDTH - 1));
          cnt   <= cnt_nxt;
          if (cnt_nxt == CNT_W'(WIDTH)) begin
            res_vld_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr       <= ~id_q;
            state     <= IDLE;
          end
        end
        default: begin
          res_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xor_seq_arbiter.sv
// Self-checking bench: per-cycle behavioural model for the 16-bit build plus directed checks (incl. a 1-bit build).
module tb_xor_seq_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  xor_seq_arbiter_if #(.WIDTH(16)) bus ();
  xor_seq_arbiter_if #(.WIDTH(1))  bus1 ();

  xor_seq_arbiter #(.WIDTH(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  xor_seq_arbiter #(.WIDTH(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: an op is either absent or has an age in cycles since its accept edge.
  bit          m_act;
  bit          m_ptr;
  bit          m_id;
  int          m_age;
  logic [15:0] m_res;

  function automatic bit exp_rdy(input bit n);
    bit v0, v1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (m_act) return 1'b0;
    if (n == 1'b0) return v0 && (!v1 || !m_ptr);
    return v1 && (!v0 || m_ptr);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_act = 1'b0;
      m_ptr = 1'b0;
      m_age = 0;
    end else if (m_act) begin
      if (m_age >= 16 && bus.res_ready) begin
        m_act = 1'b0;
        m_ptr = !m_id;
      end else begin
        m_age++;
      end
    end else if (exp_rdy(1'b0)) begin
      m_act = 1'b1; m_age = 0; m_id = 1'b0; m_res = bus.req0_a ^ bus.req0_b;
    end else if (exp_rdy(1'b1)) begin
      m_act = 1'b1; m_age = 0; m_id = 1'b1; m_res = bus.req1_a ^ bus.req1_b;
    end
  end

  // Observation records used by the directed checks.
  bit   hs0, hs1, prev_vld;
  int   r0_cnt;
  int   acc_cyc[$];
  int   vld_cyc[$];
  bit   comp_id[$];
  logic [15:0] comp_dat[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data",  bus.res_data, 0);
      chk("rst_res_id",    bus.res_id, 0);
      chk("rst_busy",      bus.busy, 0);
      hs0 = 1'b0;
      hs1 = 1'b0;
      prev_vld = 1'b0;
    end else begin
      chk("req0_ready", bus.req0_ready, exp_rdy(1'b0));
      chk("req1_ready", bus.req1_ready, exp_rdy(1'b1));
      chk("busy", bus.busy, m_act);
      chk("res_valid", bus.res_valid, m_act && m_age >= 16);
      if (m_act && m_age >= 16) begin
        chk("res_data", bus.res_data, m_res);
        chk("res_id", bus.res_id, m_id);
      end
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      if (bus.req0_ready) r0_cnt++;
      if (hs0 || hs1) acc_cyc.push_back(cyc + 1);
      if (bus.res_valid && !prev_vld) vld_cyc.push_back(cyc);
      prev_vld = bus.res_valid;
      if (bus.res_valid && bus.res_ready) begin
        comp_id.push_back(bus.res_id);
        comp_dat.push_back(bus.res_data);
      end
    end
  end

  // Requester drivers: hold valid until the requested number of ops has been accepted.
  int cnt0, cnt1;
  always @(posedge clk) begin
    #1;
    if (hs0 && cnt0 > 0) cnt0--;
    if (hs1 && cnt1 > 0) cnt1--;
    bus.req0_valid = (cnt0 > 0);
    bus.req1_valid = (cnt1 > 0);
  end

  task automatic wait_comp(input string nm, input int n);
    int k;
    k = 0;
    while (comp_id.size() < n && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, comp_id.size(), n);
  endtask

  initial begin
    int base, nv, k;
    checks = 0; failures = 0; cyc = 0;
    cnt0 = 0; cnt1 = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 16'hA5A5; bus.req0_b = 16'h0FF0;
    bus.req1_a = 16'hFFFF; bus.req1_b = 16'h1234;
    bus.res_ready = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    bus1.req0_a = 1'b0; bus1.req0_b = 1'b0;
    bus1.req1_a = 1'b0; bus1.req1_b = 1'b0;
    bus1.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op from req0
    r0_cnt = 0;
    cnt0 = 1;
    wait_comp("op1_done", 1);
    chk("op1_data", comp_dat[0], 16'hAA55);
    chk("op1_id", comp_id[0], 0);
    chk("op1_latency", vld_cyc[0] - acc_cyc[0], 16);
    chk("op1_ready_pulses", r0_cnt, 1);

    // Contention straight after reset: req0 first
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    base = comp_id.size();
    cnt0 = 1; cnt1 = 1;
    wait_comp("cont_done", base + 2);
    chk("cont_id0", comp_id[base], 0);
    chk("cont_dat0", comp_dat[base], 16'hAA55);
    chk("cont_id1", comp_id[base+1], 1);
    chk("cont_dat1", comp_dat[base+1], 16'hEDCB);

    // Fairness with both valid continuously
    base = comp_id.size();
    k = acc_cyc.size();
    cnt0 = 2; cnt1 = 2;
    wait_comp("fair_done", base + 4);
    for (int i = 0; i < 4; i++) chk("fair_id", comp_id[base+i], i % 2);
    chk("fair_spacing", acc_cyc[k+1] - acc_cyc[k], 18);

    // Backpressure in DONE
    bus.res_ready = 1'b0;
    base = comp_id.size();
    cnt0 = 1; cnt1 = 1;
    nv = 0;
    while (!bus.res_valid && nv < 100) begin
      @(negedge clk);
      nv++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_data", bus.res_data, 16'hAA55);
      chk("bp_id", bus.res_id, 0);
      chk("bp_rdy0", bus.req0_ready, 0);
      chk("bp_rdy1", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
    end
    @(posedge clk); #1 bus.res_ready = 1'b1;
    wait_comp("bp_done", base + 2);
    chk("bp_after_id", comp_id[base+1], 1);
    chk("bp_after_dat", comp_dat[base+1], 16'hEDCB);

    // Reset while at bit 7 of a RUN
    cnt0 = 1;
    k = 0;
    @(negedge clk);
    while (!hs0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid_accept_seen", hs0, 1);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.res_data, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid) nv++;
    end
    chk("mid_no_result", nv, 0);
    base = comp_id.size();
    cnt1 = 1;
    wait_comp("mid_next_done", base + 1);
    chk("mid_next_id", comp_id[base], 1);
    chk("mid_next_dat", comp_dat[base], 16'hEDCB);

    // 1-bit build
    @(posedge clk); #1;
    bus1.req0_a = 1'b1; bus1.req0_b = 1'b0; bus1.req0_valid = 1'b1;
    @(negedge clk);
    chk("w1_ready", bus1.req0_ready, 1);
    chk("w1_idle_busy", bus1.busy, 0);
    @(posedge clk); #1 bus1.req0_valid = 1'b0;
    @(negedge clk);
    chk("w1_run_valid", bus1.res_valid, 0);
    chk("w1_run_busy", bus1.busy, 1);
    @(negedge clk);
    chk("w1_valid", bus1.res_valid, 1);
    chk("w1_data", bus1.res_data, 1);
    chk("w1_id", bus1.res_id, 0);
    bus1.res_ready = 1'b1;
    @(negedge clk);
    chk("w1_valid_fall", bus1.res_valid, 0);
    chk("w1_busy_fall", bus1.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
